dram_line_requester: RTL and testbench

- Initiator-side master for the single-word DRAM request/response interface (req_valid/req_write/req_addr/req_wdata out; resp_valid/resp_rdata in; resp_ready out).
- Converts one cache-line read or write from a client (L2 refill/writeback path) into BEATS sequential 64-bit word transactions, one outstanding at a time.
- Gathers read data and returns the whole line with an error flag.
- Sits between the cache miss handler and the DRAM model/controller.

---
 rtl/dram_line_requester.sv | 148 ++++++++++++++
 tb/tb_dram_line_requester.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_line_requester.sv
// Cache-line master for the single-word DRAM interface: splits one line read or write
// into BEATS word transactions, one outstanding at a time, and gathers read data.
module dram_line_requester #(
   parameter int BEATS   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  line_req_valid,
   output logic                  line_req_ready,
   input  logic                  line_req_write,
   input  logic [63:0]           line_req_addr,
   input  logic [64*BEATS-1:0]   line_req_wdata,
   output logic                  line_resp_valid,
   input  logic                  line_resp_ready,
   output logic [64*BEATS-1:0]   line_resp_rdata,
   output logic                  line_resp_err,
   output logic                  req_valid,
   output logic                  req_write,
   output logic [63:0]           req_addr,
   output logic [63:0]           req_wdata,
   output logic                  resp_ready,
   input  logic                  resp_valid,
   input  logic [63:0]           resp_rdata
);

   localparam int OFFS = $clog2(BEATS) + 3;
   localparam int BW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int LW   = 64 * BEATS;

   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [TW-1:0] TCNT_MAX  = '1;
   localparam logic [TW-1:0] TCNT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [63:0]   BASE_MASK = ~((64'd1 << OFFS) - 64'd1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t          state, state_nx;
   logic [BW-1:0]   beat, beat_nx;
   logic [TW-1:0]   tcnt, tcnt_nx;
   logic [63:0]     base, base_nx;
   logic            wr_flag, wr_flag_nx;
   logic [LW-1:0]   wdata_q, wdata_nx;
   logic [LW-1:0]   rdata_q, rdata_nx;
   logic            err_q, err_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         beat    <= '0;
         tcnt    <= '0;
         base    <= '0;
         wr_flag <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         beat    <= beat_nx;
         tcnt    <= tcnt_nx;
         base    <= base_nx;
         wr_flag <= wr_flag_nx;
         wdata_q <= wdata_nx;
         rdata_q <= rdata_nx;
         err_q   <= err_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      beat_nx    = beat;
      tcnt_nx    = tcnt;
      base_nx    = base;
      wr_flag_nx = wr_flag;
      wdata_nx   = wdata_q;
      rdata_nx   = rdata_q;
      err_nx     = err_q;

      case (state)
         IDLE: begin
            if (line_req_valid) begin
               base_nx    = line_req_addr & BASE_MASK;
               wr_flag_nx = line_req_write;
               wdata_nx   = line_req_wdata;
               rdata_nx   = '0;
               err_nx     = 1'b0;
               beat_nx    = '0;
               state_nx   = ISSUE;
            end
         end

         // Handshake completes on this edge because resp_ready is high alongside req_valid.
         ISSUE: begin
            tcnt_nx  = '0;
            state_nx = WAIT;
         end

         // A response arriving on the timeout boundary cycle takes priority over the abort.
         WAIT: begin
            if (resp_valid) begin
               if (!wr_flag) begin
                  rdata_nx[int'(beat)*64 +: 64] = resp_rdata;
               end
               if (beat == LAST_BEAT) begin
                  state_nx = RESP;
               end else begin
                  beat_nx  = beat + 1'b1;
                  state_nx = ISSUE;
               end
            end else begin
               if (tcnt != TCNT_MAX) begin
                  tcnt_nx = tcnt + 1'b1;
               end
               if ((TIMEOUT != 0) && (tcnt == TCNT_LAST)) begin
                  err_nx   = 1'b1;
                  state_nx = RESP;
               end
            end
         end

         RESP: begin
            if (line_resp_ready) begin
               state_nx = IDLE;
            end
         end

         default: state_nx = IDLE;
      endcase
   end

   // Word-side outputs derive from registered state, so they stay put while waiting.
   assign line_req_ready  = (state == IDLE);
   assign line_resp_valid = (state == RESP);
   assign line_resp_rdata = rdata_q;
   assign line_resp_err   = err_q;
   assign req_valid       = (state == ISSUE);
   assign resp_ready      = (state == ISSUE) || (state == WAIT);
   assign req_write       = wr_flag;
   assign req_addr        = base + (64'(beat) << 3);
   assign req_wdata       = wdata_q[int'(beat)*64 +: 64];

endmodule

// File: tb/tb_dram_line_requester.sv
// Randomized bench for dram_line_requester: a delay-programmable DRAM responder plus a
// line-level reference model predicting addresses, data, error flag and latency.
module tb_dram_line_requester;

   localparam int BEATS   = 8;
   localparam int TIMEOUT = 4;
   localparam int LW      = 64 * BEATS;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            line_req_valid;
   logic            line_req_ready;
   logic            line_req_write;
   logic [63:0]     line_req_addr;
   logic [LW-1:0]   line_req_wdata;
   logic            line_resp_valid;
   logic            line_resp_ready;
   logic [LW-1:0]   line_resp_rdata;
   logic            line_resp_err;
   logic            req_valid;
   logic            req_write;
   logic [63:0]     req_addr;
   logic [63:0]     req_wdata;
   logic            resp_ready;
   logic            resp_valid;
   logic [63:0]     resp_rdata;

   int checks = 0;
   int errors = 0;

   logic [63:0] mem [logic [63:0]];
   int          delay_tab [BEATS];
   int          drop_beat = -1;
   int          req_total = 0;
   int          req_start = 0;
   logic [63:0] obs_addr [$];
   logic        obs_write [$];
   logic [63:0] obs_wdata [$];
   bit          spur_pulse = 1'b0;

   always #5 clk = ~clk;

   dram_line_requester #(.BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .line_req_valid  (line_req_valid),
      .line_req_ready  (line_req_ready),
      .line_req_write  (line_req_write),
      .line_req_addr   (line_req_addr),
      .line_req_wdata  (line_req_wdata),
      .line_resp_valid (line_resp_valid),
      .line_resp_ready (line_resp_ready),
      .line_resp_rdata (line_resp_rdata),
      .line_resp_err   (line_resp_err),
      .req_valid       (req_valid),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_ready      (resp_ready),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] dramWord(input logic [63:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[31:0] ^ 32'h5A5A_0F0F, a[31:0]};
   endfunction

   // DRAM stand-in: answers beat k delay_tab[k] cycles into WAIT, stays silent on drop_beat.
   initial begin : responder
      int          idx;
      int          d;
      logic [63:0] a;
      logic [63:0] w;
      logic [63:0] rd;
      resp_valid = 1'b0;
      resp_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n && req_valid) begin
            idx = req_total - req_start;
            a   = req_addr;
            w   = req_wdata;
            obs_addr.push_back(a);
            obs_write.push_back(req_write);
            obs_wdata.push_back(w);
            req_total++;
            if (idx != drop_beat) begin
               d = (idx >= 0 && idx < BEATS) ? delay_tab[idx] : 1;
               if (req_write) begin
                  mem[a] = w;
                  rd = {$urandom, $urandom};
               end else begin
                  rd = dramWord(a);
               end
               @(posedge clk);
               repeat (d - 1) @(posedge clk);
               #1 resp_valid = 1'b1;
               resp_rdata = rd;
               @(posedge clk);
               #1 resp_valid = 1'b0;
               resp_rdata = {$urandom, $urandom};
            end
         end else if (spur_pulse) begin
            #1 resp_valid = 1'b1;
            resp_rdata = {$urandom, $urandom};
            @(posedge clk);
            #1 resp_valid = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation hung");
   end

   // One full line transaction, checked against the line-level model.
   task automatic applyStimulus(input logic wr, input logic [63:0] addr,
                                input logic [LW-1:0] wd, input int bp, input bit spur);
      logic [63:0]   base;
      logic [LW-1:0] exp_rd;
      int            exp_lat;
      int            exp_n;
      int            n;
      int            got;
      base    = addr & ~(64'(BEATS * 8) - 64'd1);
      exp_n   = (drop_beat < 0) ? BEATS : drop_beat + 1;
      exp_rd  = '0;
      exp_lat = 0;
      for (int i = 0; i < exp_n; i++) begin
         exp_lat += 1 + ((i == drop_beat) ? TIMEOUT : delay_tab[i]);
         if (!wr && i != drop_beat) exp_rd[i*64 +: 64] = dramWord(base + 64'(8 * i));
      end
      req_start = req_total;

      n = 0;
      while (!line_req_ready && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      checkOutput("line_req_ready_idle", 64'(line_req_ready), 64'd1);
      line_req_valid = 1'b1;
      line_req_write = wr;
      line_req_addr  = addr;
      line_req_wdata = wd;
      @(posedge clk);
      #1 line_req_valid = 1'b0;
      line_req_addr  = {$urandom, $urandom};
      line_req_write = ~wr;

      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (!line_resp_valid && n < 400);
      checkOutput("latency", 64'(n), 64'(exp_lat));

      got = req_total - req_start;
      checkOutput("req_count", 64'(got), 64'(exp_n));
      for (int i = 0; i < got && i < exp_n; i++) begin
         checkOutput($sformatf("req_addr[%0d]", i), obs_addr[req_start + i], base + 64'(8 * i));
         checkOutput($sformatf("req_write[%0d]", i), 64'(obs_write[req_start + i]), 64'(wr));
         if (wr) checkOutput($sformatf("req_wdata[%0d]", i), obs_wdata[req_start + i], wd[i*64 +: 64]);
      end
      for (int i = 0; i < BEATS; i++)
         checkOutput($sformatf("rdata[%0d]", i), line_resp_rdata[i*64 +: 64], exp_rd[i*64 +: 64]);
      checkOutput("err", 64'(line_resp_err), 64'(drop_beat >= 0));

      for (int c = 0; c < bp; c++) begin
         if (spur && c == bp / 2) spur_pulse = 1'b1;
         @(posedge clk);
         #1 spur_pulse = 1'b0;
         checkOutput("bp_resp_valid", 64'(line_resp_valid), 64'd1);
         checkOutput("bp_req_ready", 64'(line_req_ready), 64'd0);
         checkOutput("bp_err", 64'(line_resp_err), 64'(drop_beat >= 0));
         for (int i = 0; i < BEATS; i++)
            checkOutput($sformatf("bp_rdata[%0d]", i), line_resp_rdata[i*64 +: 64], exp_rd[i*64 +: 64]);
      end
      checkOutput("bp_no_extra_req", 64'(req_total - req_start), 64'(exp_n));

      line_resp_ready = 1'b1;
      @(posedge clk);
      #1 line_resp_ready = 1'b0;
      checkOutput("resp_done_valid", 64'(line_resp_valid), 64'd0);
      checkOutput("resp_done_ready", 64'(line_req_ready), 64'd1);
   endtask

   task automatic setDelays(input int d);
      for (int i = 0; i < BEATS; i++) delay_tab[i] = d;
   endtask

   initial begin : main
      logic [LW-1:0] wd;
      logic [63:0]   addr;
      int            n;

      line_req_valid  = 1'b0;
      line_req_write  = 1'b0;
      line_req_addr   = '0;
      line_req_wdata  = '0;
      line_resp_ready = 1'b0;
      setDelays(1);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_line_req_ready", 64'(line_req_ready), 64'd1);
      checkOutput("rst_line_resp_valid", 64'(line_resp_valid), 64'd0);
      checkOutput("rst_req_valid", 64'(req_valid), 64'd0);
      checkOutput("rst_resp_ready", 64'(resp_ready), 64'd0);
      checkOutput("rst_req_addr", req_addr, 64'd0);
      checkOutput("rst_req_wdata", req_wdata, 64'd0);
      checkOutput("rst_req_write", 64'(req_write), 64'd0);
      checkOutput("rst_err", 64'(line_resp_err), 64'd0);
      checkOutput("rst_rdata_or", 64'(|line_resp_rdata), 64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed read of a preloaded line.
      for (int i = 0; i < BEATS; i++) mem[64'h200 + 64'(8 * i)] = 64'h1000 + 64'(i);
      applyStimulus(1'b0, 64'h200, '0, 0, 1'b0);
      for (int i = 0; i < BEATS; i++)
         checkOutput($sformatf("read_lit[%0d]", i), line_resp_rdata[i*64 +: 64], 64'h1000 + 64'(i));

      // Write then read back.
      for (int i = 0; i < BEATS; i++) wd[i*64 +: 64] = 64'hA5A5_0000 + 64'(i);
      applyStimulus(1'b1, 64'h400, wd, 0, 1'b0);
      applyStimulus(1'b0, 64'h400, '0, 0, 1'b0);
      for (int i = 0; i < BEATS; i++)
         checkOutput($sformatf("wr_rd_lit[%0d]", i), line_resp_rdata[i*64 +: 64], 64'hA5A5_0000 + 64'(i));

      // Unaligned request address.
      applyStimulus(1'b0, 64'h23F, '0, 0, 1'b0);
      checkOutput("unaligned_first", obs_addr[req_start], 64'h200);
      checkOutput("unaligned_last", obs_addr[req_start + BEATS - 1], 64'h238);

      // Beat 3 never answered.
      drop_beat = 3;
      applyStimulus(1'b0, 64'h200, '0, 0, 1'b0);
      checkOutput("timeout_err_lit", 64'(line_resp_err), 64'd1);
      checkOutput("timeout_word3", line_resp_rdata[3*64 +: 64], 64'd0);
      drop_beat = -1;

      // Backpressure with a spurious DRAM response while waiting on the client.
      applyStimulus(1'b0, 64'h400, '0, 10, 1'b1);

      // Reset during WAIT of beat 4.
      drop_beat = 4;
      req_start = req_total;
      line_req_valid = 1'b1;
      line_req_write = 1'b0;
      line_req_addr  = 64'h200;
      @(posedge clk);
      #1 line_req_valid = 1'b0;
      n = 0;
      while ((req_total - req_start) < 5 && n < 100) begin
         @(negedge clk);
         #1 n++;
      end
      checkOutput("rst_reached_beat4", 64'(req_total - req_start), 64'd5);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("midrst_req_valid", 64'(req_valid), 64'd0);
      checkOutput("midrst_resp_ready", 64'(resp_ready), 64'd0);
      checkOutput("midrst_resp_valid", 64'(line_resp_valid), 64'd0);
      checkOutput("midrst_req_addr", req_addr, 64'd0);
      checkOutput("midrst_rdata0", line_resp_rdata[63:0], 64'd0);
      checkOutput("midrst_err", 64'(line_resp_err), 64'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("postrst_req_ready", 64'(line_req_ready), 64'd1);
      checkOutput("postrst_resp_valid", 64'(line_resp_valid), 64'd0);
      drop_beat = -1;
      applyStimulus(1'b0, 64'h200, '0, 0, 1'b0);

      // Randomized traffic over a small pool of lines so reads see earlier writes.
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < BEATS; i++) begin
            delay_tab[i] = int'($urandom_range(1, TIMEOUT));
            wd[i*64 +: 64] = {$urandom, $urandom};
         end
         drop_beat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
         if ($urandom_range(0, 1) == 1)
            addr = 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 4095));
         else
            addr = 64'h1000_0000 + 64'($urandom_range(0, 15) * 64) + 64'($urandom_range(0, 63));
         applyStimulus(1'($urandom_range(0, 1)), addr, wd, int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));
      end
      drop_beat = -1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
